bram_stream_reader: RTL and testbench

- Read-side master for the dual-port block RAM. Drives port B (addrb, enb) and consumes doutb.
- On a start command it streams a contiguous address range out as a valid/ready word stream, with m_last on the final word. Typical consumers are the display, serializer or checksum logic.
- Hides the fixed RAM read latency behind a small credit-controlled FIFO, so downstream backpressure never loses or duplicates a word.

---
 rtl/bram_stream_reader_pkg.sv | 28 ++
 rtl/bram_stream_reader_if.sv | 40 ++++
 rtl/bram_stream_reader_sync_fifo.sv | 67 ++++++
 rtl/bram_stream_reader.sv | 131 +++++++++++++
 tb/tb_bram_stream_reader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_pkg
// Shared definitions for the block-RAM stream reader: default bus widths
// (kept in step with the bRAM port B), FSM state encoding and the FIFO
// depth rule that hides the RAM read latency.
// ---------------------------------------------------------------------------
package bram_stream_reader_pkg;

    localparam int ADDR_W_DEFAULT = 19;
    localparam int DATA_W_DEFAULT = 16;
    localparam int LEN_W_DEFAULT  = 20;
    localparam int RD_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // RD_LAT words can be in flight plus two more buffered, which is enough
    // to keep one word per cycle flowing once the pipeline is full.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(RD_LAT_DEFAULT);

endpackage

// File: rtl/bram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_if
// Groups the reader's command, bRAM port B and output stream signals.
//   command : start, base_addr, length -> busy, done
//   bRAM    : bram_addrb, bram_enb -> bram_doutb
//   stream  : m_data, m_valid, m_last -> m_ready
// master = the reader, slave = the surrounding environment.
// ---------------------------------------------------------------------------
interface bram_stream_reader_if
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] bram_addrb;
    logic              bram_enb;
    logic [DATA_W-1:0] bram_doutb;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  start, base_addr, length, bram_doutb, m_ready,
        output busy, done, bram_addrb, bram_enb, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, length, bram_doutb, m_ready,
        input  busy, done, bram_addrb, bram_enb, m_data, m_valid, m_last
    );
endinterface

// File: rtl/bram_stream_reader_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic first-word-fall-through FIFO with occupancy count. The head entry
// is visible on o_rdata whenever o_count != 0.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_wdata
//   i_pop      : consume head (ignored when empty)
//   o_rdata    : head entry
//   o_count    : number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Streams length words starting at base_addr out of bRAM port B as a
// valid/ready stream with m_last on the final word. Reads are issued only
// when a FIFO slot is guaranteed, so backpressure never drops a word.
//   clk   : system clock (also bRAM clkb)
//   rst_n : synchronous active-low reset
//   bus   : command, bRAM port B and output stream (master modport)
//
//   state    | meaning
//   ST_IDLE  | waiting for start; zero-length start answers with done only
//   ST_RUN   | issuing reads while words remain and credit is available
//   ST_DRAIN | all reads issued; waiting for the last word to be accepted
// ---------------------------------------------------------------------------
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int RD_LAT = RD_LAT_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_stream_reader_if.master bus
);
    localparam int DEPTH = fifo_depth(RD_LAT);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(2 * DEPTH + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [RD_LAT-1:0] r_vld_sr;
    logic [RD_LAT-1:0] r_last_sr;
    logic              r_done;

    logic              w_accept;
    logic              w_enb;
    logic              w_done_nxt;
    logic              w_issue_last;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_valid;
    logic              w_head_last;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W:0]   w_fifo_head;
    logic [OCC_W-1:0]  w_occ;

    assign w_accept     = bus.start && (bus.length != '0);
    assign w_issue_last = (r_issued == r_len - LEN_W'(1));
    // Outstanding words: reads still in the RAM pipeline plus words buffered.
    assign w_occ        = OCC_W'($countones(r_vld_sr)) + OCC_W'(w_fifo_count);
    assign w_push       = r_vld_sr[RD_LAT-1];
    assign w_fifo_valid = (w_fifo_count != '0);
    assign w_head_last  = w_fifo_head[DATA_W];
    assign w_pop        = w_fifo_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept)                  w_state_nxt = ST_RUN;
            ST_RUN:   if (w_enb && w_issue_last)     w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_head_last)      w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enb      = 1'b0;
        w_done_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE:  w_done_nxt = bus.start && (bus.length == '0);
            ST_RUN:   w_enb      = (w_occ < OCC_W'(DEPTH));
            ST_DRAIN: w_done_nxt = w_pop && w_head_last;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_len     <= '0;
            r_issued  <= '0;
            r_vld_sr  <= '0;
            r_last_sr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= w_done_nxt;
            // Valid/last ride alongside each read through the RAM latency.
            r_vld_sr  <= (r_vld_sr << 1) | RD_LAT'(w_enb);
            r_last_sr <= (r_last_sr << 1) | RD_LAT'(w_enb && w_issue_last);
            if ((r_state == ST_IDLE) && w_accept) begin
                r_base   <= bus.base_addr;
                r_len    <= bus.length;
                r_issued <= '0;
            end else if (w_enb) begin
                r_issued <= r_issued + LEN_W'(1);
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_last_sr[RD_LAT-1], bus.bram_doutb}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign bus.bram_enb   = w_enb;
    assign bus.bram_addrb = r_base + ADDR_W'(r_issued);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = r_done;
    assign bus.m_valid    = w_fifo_valid;
    assign bus.m_data     = w_fifo_valid ? w_fifo_head[DATA_W-1:0] : '0;
    assign bus.m_last     = w_fifo_valid && w_head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 20;
    localparam int RD_LAT = 1;
    localparam int MAX_OUTSTANDING = RD_LAT + 2;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int len;
        int ready_mode;     // 0 always ready, 1 toggle, 2 random
        int pat;            // memory content pattern
        int restart_at;     // cycle of an extra start pulse, -1 none
        int exp_first;      // expected first word, -1 unchecked
        int exp_final;      // expected final word, -1 unchecked
        int exp_done_cyc;   // expected done cycle, -1 unchecked
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   g_pat;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    bram_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        case (g_pat)
            0:       return DATA_W'(a * ADDR_W'(3));
            1:       return DATA_W'(a);
            default: return DATA_W'(a) ^ 16'hA5C3;
        endcase
    endfunction

    // Synchronous RAM with RD_LAT = 1: data appears the cycle after enb.
    always @(posedge clk) begin
        if (bus.bram_enb === 1'b1) bus.bram_doutb <= mem_val(bus.bram_addrb);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered at #1 after a clock edge; that cycle is cycle 0 of the command.
    task automatic run_cmd(input vec_t v, input string nm);
        logic [DATA_W-1:0] got_data[$];
        logic              got_last[$];
        logic [ADDR_W-1:0] iss_addr[$];
        int                hs_cyc[$];
        int done_cnt = 0, done_cyc = -1, first_v = -1;
        int busy_bad = 0, stall_bad = 0, occ_bad = 0;
        int outstanding = 0, c = 0, post = 0;
        logic prev_stall = 1'b0, prev_last = 1'b0, rdy, exp_busy;
        logic [DATA_W-1:0] prev_data = '0;

        g_pat         = v.pat;
        bus.base_addr = v.base;
        bus.length    = LEN_W'(v.len);
        bus.start     = 1'b1;
        while (post < 4 && c < 400) begin
            @(posedge clk); #1; c++;
            if (c == v.restart_at) begin
                bus.start = 1'b1; bus.base_addr = 19'd999; bus.length = LEN_W'(2);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.bram_enb) begin
                iss_addr.push_back(bus.bram_addrb);
                outstanding++;
            end
            if (outstanding > MAX_OUTSTANDING) occ_bad++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            exp_busy = (v.len != 0) && (done_cyc < 0);
            if (bus.busy !== exp_busy) busy_bad++;
            if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data ||
                               bus.m_last !== prev_last)) stall_bad++;
            if (bus.m_valid && first_v < 0) first_v = c;
            case (v.ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 1);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.m_ready = rdy;
            if (bus.m_valid && rdy) begin
                got_data.push_back(bus.m_data);
                got_last.push_back(bus.m_last);
                hs_cyc.push_back(c);
                outstanding--;
            end
            prev_stall = bus.m_valid && !rdy;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (done_cyc >= 0) post++;
        end

        chk({nm, "_done_once"}, done_cnt, 1);
        chk({nm, "_words"}, got_data.size(), v.len);
        chk({nm, "_issues"}, iss_addr.size(), v.len);
        chk({nm, "_busy_bad"}, busy_bad, 0);
        chk({nm, "_stall_bad"}, stall_bad, 0);
        chk({nm, "_outstanding_bad"}, occ_bad, 0);
        for (int i = 0; i < got_data.size() && i < v.len; i++) begin
            chk($sformatf("%s_data%0d", nm, i), got_data[i],
                mem_val(ADDR_W'(v.base + ADDR_W'(i))));
            chk($sformatf("%s_last%0d", nm, i), got_last[i], (i == v.len - 1) ? 1 : 0);
        end
        for (int i = 0; i < iss_addr.size() && i < v.len; i++)
            chk($sformatf("%s_addr%0d", nm, i), iss_addr[i], ADDR_W'(v.base + ADDR_W'(i)));
        if (v.len == 0) begin
            chk({nm, "_no_valid"}, first_v, -1);
            chk({nm, "_zero_done_cyc"}, done_cyc, 1);
        end else if (hs_cyc.size() > 0) begin
            chk({nm, "_done_after_last"}, done_cyc, hs_cyc[$] + 1);
            if (v.ready_mode == 0) begin
                chk({nm, "_first_valid_cyc"}, first_v, 2 + RD_LAT);
                chk({nm, "_no_bubbles"}, hs_cyc[$] - hs_cyc[0], v.len - 1);
            end
        end
        if (v.exp_done_cyc >= 0) chk({nm, "_done_cyc"}, done_cyc, v.exp_done_cyc);
        if (v.exp_first >= 0 && got_data.size() > 0) chk({nm, "_first"}, got_data[0], v.exp_first);
        if (v.exp_final >= 0 && got_data.size() > 0) chk({nm, "_final"}, got_data[$], v.exp_final);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int   hs, c;

        tbl[0] = '{19'd5,       4, 0, 0, -1, 15,      24,  7};
        tbl[1] = '{19'd0,       8, 1, 1, -1, 0,       7,   -1};
        tbl[2] = '{19'h7FFFE,   4, 0, 1, -1, 16'hFFFE, 1,  7};
        tbl[3] = '{19'd10,      0, 0, 1, -1, -1,      -1,  1};
        tbl[4] = '{19'd40,      6, 0, 1, 3,  40,      45,  9};

        // Reset with random inputs for three cycles.
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.start     = 1'($urandom_range(0, 1));
            bus.base_addr = ADDR_W'($urandom);
            bus.length    = LEN_W'($urandom);
            bus.m_ready   = 1'($urandom_range(0, 1));
        end
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_enb", bus.bram_enb, 0);
        chk("rst_addrb", bus.bram_addrb, 0);
        bus.start = 1'b0; bus.m_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset after two of eight words, then a fresh short command.
        g_pat = 1;
        bus.base_addr = '0; bus.length = LEN_W'(8); bus.start = 1'b1; bus.m_ready = 1'b1;
        hs = 0; c = 0;
        while (hs < 2 && c < 50) begin
            @(posedge clk); #1; c++;
            bus.start = 1'b0;
            if (bus.m_valid && bus.m_ready) hs++;
        end
        chk("midrst_reached", hs, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_last", bus.m_last, 0);
        chk("midrst_m_data", bus.m_data, 0);
        chk("midrst_enb", bus.bram_enb, 0);
        chk("midrst_addrb", bus.bram_addrb, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rv = '{19'd100, 2, 0, 1, -1, 100, 101, 5};
        run_cmd(rv, "after_rst");

        // Random commands under random backpressure.
        for (int i = 0; i < 6; i++) begin
            rv = '{ADDR_W'($urandom), int'($urandom_range(1, 24)), 2, 2, -1, -1, -1, -1};
            run_cmd(rv, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
